// File: rtl/key_event_encoder.sv
// key_event_encoder
//   Watches eight control levels and turns each press/release change into a
//   key event byte {press, 4'b0000, key[2:0]}. Each byte is sent as a UART 8N1
//   frame (LSB first, idle high). The same event is also shown on a parallel
//   strobe interface so it can be looped back into the decoder.
//
// Ports
//   clk          system clock, all state on the rising edge
//   rst          asynchronous active-high reset
//   controls_in  raw levels, bit i = key i held
//   tx           UART serial output
//   busy         high from START through STOP
//   ev_strobe    one-cycle pulse when an event is committed
//   ev_key_val   key index of the last committed event
//   ev_press     1 = press, 0 = release, of the last committed event
module key_event_encoder #(
   parameter int CLKS_PER_BIT = 868,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] controls_in,
   output logic       tx,
   output logic       busy,
   output logic       ev_strobe,
   output logic [2:0] ev_key_val,
   output logic       ev_press
);

   localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t                      state_q, state_d;
   logic [SYNC_STAGES-1:0][7:0] sync_q;
   logic [7:0]                  last_q, last_d;
   logic [7:0]                  byte_q, byte_d;
   logic [BW-1:0]               baud_q, baud_d;
   logic [2:0]                  bit_q, bit_d;
   logic                        tx_q, tx_d;
   logic                        busy_q, busy_d;
   logic                        strobe_q, strobe_d;
   logic [2:0]                  key_q, key_d;
   logic                        press_q, press_d;

   logic [7:0] sync;
   logic [7:0] diff;
   logic [2:0] sel;
   logic       baud_end;

   assign sync     = sync_q[SYNC_STAGES-1];
   // Compared against what was last reported, not the previous sample, so
   // toggles that come and go during a frame collapse to nothing.
   assign diff     = sync ^ last_q;
   assign baud_end = (baud_q == BAUD_LAST);

   // Lowest set index wins.
   always_comb begin
      sel = 3'd0;
      for (int i = 7; i >= 0; i--)
         if (diff[i]) sel = 3'(i);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q[0] <= controls_in;
         for (int s = 1; s < SYNC_STAGES; s++)
            sync_q[s] <= sync_q[s-1];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         last_q   <= 8'h00;
         byte_q   <= 8'h00;
         baud_q   <= '0;
         bit_q    <= 3'd0;
         tx_q     <= 1'b1;
         busy_q   <= 1'b0;
         strobe_q <= 1'b0;
         key_q    <= 3'd0;
         press_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         last_q   <= last_d;
         byte_q   <= byte_d;
         baud_q   <= baud_d;
         bit_q    <= bit_d;
         tx_q     <= tx_d;
         busy_q   <= busy_d;
         strobe_q <= strobe_d;
         key_q    <= key_d;
         press_q  <= press_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      last_d   = last_q;
      byte_d   = byte_q;
      baud_d   = baud_q;
      bit_d    = bit_q;
      tx_d     = tx_q;
      busy_d   = busy_q;
      strobe_d = 1'b0;
      key_d    = key_q;
      press_d  = press_q;
      unique case (state_q)
         IDLE: begin
            tx_d   = 1'b1;
            busy_d = 1'b0;
            if (diff != 8'h00) begin
               // last_sent updates now so changes during the frame are
               // judged against the value being transmitted.
               last_d[sel] = sync[sel];
               byte_d      = {sync[sel], 4'b0000, sel};
               key_d       = sel;
               press_d     = sync[sel];
               strobe_d    = 1'b1;
               state_d     = START;
               tx_d        = 1'b0;
               busy_d      = 1'b1;
               baud_d      = '0;
            end
         end
         START: begin
            if (baud_end) begin
               baud_d  = '0;
               bit_d   = 3'd0;
               tx_d    = byte_q[0];
               state_d = DATA;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         DATA: begin
            if (baud_end) begin
               baud_d = '0;
               if (bit_q == 3'd7) begin
                  tx_d    = 1'b1;
                  state_d = STOP;
               end else begin
                  bit_d = bit_q + 3'd1;
                  tx_d  = byte_q[bit_q + 3'd1];
               end
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         STOP: begin
            if (baud_end) begin
               baud_d  = '0;
               busy_d  = 1'b0;
               state_d = IDLE;
            end else begin
               baud_d = baud_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign tx         = tx_q;
   assign busy       = busy_q;
   assign ev_strobe  = strobe_q;
   assign ev_key_val = key_q;
   assign ev_press   = press_q;

endmodule

// File: doc/key_event_encoder.md
Name: key_event_encoder

Overview:
- Transmit-side counterpart of the Bluetooth controller decoder.
- Watches eight local control levels and detects press/release changes.
- Encodes each change as a key event byte and sends it out as a UART 8N1 frame.
- Also presents each event on a parallel key_val/press/ready-style strobe, so it can be looped back into the decoder for local test.

Parameters:
- CLKS_PER_BIT, 868: clock cycles per UART bit (100 MHz / 115200 baud); legal range >= 2.
- SYNC_STAGES, 2: synchronizer flops on controls_in; legal range >= 2.

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- controls_in  input  8  raw control levels; bit i = key i held (1) or released (0).
- tx  output  1  UART serial out, 8N1, LSB first, idle high.
- busy  output  1  high while a frame is in progress (START through STOP).
- ev_strobe  output  1  one-cycle pulse when an event is committed for sending.
- ev_key_val  output  3  index of the key in the committed event.
- ev_press  output  1  1 = press, 0 = release, for the committed event.

Behaviour:
- Reset values (asynchronous, all outputs and state):
  - tx=1, busy=0, ev_strobe=0, ev_key_val=0, ev_press=0.
  - State=IDLE, synchronizer flops=0, last_sent=8'h00, bit and baud counters=0.
- Synchronization:
  - controls_in passes through SYNC_STAGES flops to give sync[7:0].
- Change detection:
  - diff = sync ^ last_sent, evaluated combinationally.
  - Toggles that occur while busy are coalesced: only the level present at selection time is sent.
  - A press followed by a release before selection produces no event.
- Arbitration: the lowest index i with diff[i]=1 wins.
- Event byte: {press, 4'b0000, key_val[2:0]}; bit7 = press, bits 2:0 = key index.
- State machine IDLE -> START -> DATA -> STOP -> IDLE:
  - IDLE, cycle N with diff != 0, on edge N+1:
    - last_sent[i] <= sync[i]; latch the byte; ev_key_val <= i; ev_press <= sync[i].
    - ev_strobe=1 for that cycle only; state <= START; tx <= 0; busy <= 1.
  - START: hold tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA:
    - tx = byte[bit index], each bit held for CLKS_PER_BIT cycles.
    - After bit 7 completes, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE and set busy=0 in the same edge.
- Back-to-back events:
  - If diff != 0 in the first IDLE cycle, the next frame starts one cycle after STOP ends.
  - Minimum idle gap is therefore 1 clock.
- Frame length: 10*CLKS_PER_BIT cycles from tx falling to the return to IDLE.
- Latency: a controls_in change reaches sync after SYNC_STAGES edges. The next edge (if IDLE) asserts ev_strobe and drops tx.
- ev_key_val and ev_press hold their value until the next event.
- last_sent is updated at selection, not at frame end. A change during the frame is therefore seen against the new value.
- Reset mid-frame:
  - tx returns to 1 immediately (asynchronously) and the frame is abandoned.
  - last_sent is cleared, so any key held at release of reset is re-reported as a press.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps; no drift across bits.

Test Plan (CLKS_PER_BIT=4):
- Reset check: reset asserted, then released with controls_in=0 -> tx=1, busy=0, ev_strobe never pulses over 100 cycles.
- Single press: controls_in 0x00 -> 0x04 (key 2):
  - One ev_strobe with ev_key_val=2, ev_press=1.
  - tx frame is 0, then bits 0,1,0,0,0,0,0,1, then 1; 40 cycles total.
- Release: controls_in 0x04 -> 0x00 -> byte 0x02 sent, ev_press=0.
- Simultaneous change: controls_in 0x00 -> 0x81:
  - Frame for byte 0x80 (key 0 press), then after one idle cycle a frame for 0x87 (key 7 press).
  - Exactly two strobes.
- Glitch coalescing: during a busy frame, key 3 goes 0 -> 1 -> 0 before STOP -> no event is generated for key 3.
- Reset mid-frame: assert rst during DATA bit 4 -> tx=1 immediately, busy=0. After release with controls_in=0x01, a fresh 0x80 frame is sent.
